// File: rtl/lcd_pkg.sv
// Shared LCD definitions: ST7789 command opcodes, FIFO word layout and
// the rectangle-fill state encoding.
// Used by the rect-fill producer and by later bitmap/text writers.
package lcd_pkg;

  // ST7789 command opcodes
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // FIFO word: bit RS_BIT carries the RS line (0 = command, 1 = data)
  localparam int RS_BIT = 8;

  // Window header is CASET + 4 bytes, RASET + 4 bytes, RAMWR
  localparam logic [3:0] HDR_LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIX_HI,
    PIX_LO,
    DONE
  } rect_fill_state_t;

  // Build a 9-bit FIFO word from an RS value and a payload byte
  function automatic logic [8:0] mk_word(input logic rs, input logic [7:0] b);
    logic [8:0] w;
    w         = {1'b0, b};
    w[RS_BIT] = rs;
    return w;
  endfunction

endpackage

// File: rtl/lcd_win_counter.sv
// Column/row scan counter for a rectangular window, column-major inner loop.
// Latency: load/advance take effect on the next clock; last_o is combinational.
// Backpressure: none internally; caller pulses advance_i once per pixel.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load_i              move to (x_first_i, y_first_i)
//   advance_i           step to the next pixel (ignored on the last pixel)
//   x/y_first/last_i    inclusive window bounds, held stable by the caller
//   last_o              current position is (x_last_i, y_last_i)
module lcd_win_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [W-1:0] x_first_i,
  input  logic [W-1:0] x_last_i,
  input  logic [W-1:0] y_first_i,
  input  logic [W-1:0] y_last_i,
  output logic         last_o
);

  logic [W-1:0] col_q, col_d;
  logic [W-1:0] row_q, row_d;
  logic         col_last;

  // Compare before incrementing so a window ending at the top code never wraps
  assign col_last = (col_q == x_last_i);
  assign last_o   = col_last && (row_q == y_last_i);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_i) begin
      col_d = x_first_i;
      row_d = y_first_i;
    end else if (advance_i && !last_o) begin
      if (col_last) begin
        col_d = x_first_i;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/lcd_rect_fill.sv
// Emits a full ST7789 window-fill (CASET/RASET/RAMWR + W*H RGB565 pixels) as 9-bit FIFO words.
// Latency: start in cycle N -> first word valid in N+1; one word per cycle with ready high.
// Backpressure: valid/data registered and held until ready; ready may drop on any cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 fill request, sampled only in IDLE
//   x0, x1, y0, y1        inclusive window bounds, latched on accepted start
//   colour                RGB565 fill colour, latched on accepted start
//   busy                  high whenever not IDLE
//   done, err             one-cycle end-of-transaction pulse; err marks an invalid rectangle
//   valid, ready, data    FIFO write port (bit 8 = RS, bits 7:0 = payload)
module lcd_rect_fill
  import lcd_pkg::*;
#(
  parameter int COORD_WIDTH = 9,
  parameter int WORD_WIDTH  = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] y1,
  input  logic [15:0]            colour,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   valid,
  input  logic                   ready,
  output logic [WORD_WIDTH-1:0]  data
);

  if (WORD_WIDTH != 9) begin : g_bad_word_width
    $error("lcd_rect_fill: WORD_WIDTH must be 9");
  end
  if (COORD_WIDTH < 1 || COORD_WIDTH > 16) begin : g_bad_coord_width
    $error("lcd_rect_fill: COORD_WIDTH must be in 1..16");
  end

  rect_fill_state_t state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [8:0]       data_q, data_d;
  logic             err_q, err_d;

  logic [COORD_WIDTH-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0]            colour_q;

  logic        latch_en;
  logic        cnt_load;
  logic        cnt_adv;
  logic        pix_last;
  logic        xfer;
  logic [3:0]  hdr_sel;
  logic [8:0]  hdr_word;
  logic [15:0] x0_w, x1_w, y0_w, y1_w;

  assign xfer = valid_q && ready;

  // Coordinates travel as 16-bit big-endian values regardless of COORD_WIDTH
  assign x0_w = 16'(x0_q);
  assign x1_w = 16'(x1_q);
  assign y0_w = 16'(y0_q);
  assign y1_w = 16'(y1_q);

  // Header mux looks one word ahead: the registered data holds word idx_q,
  // so on a transfer the next word to load is idx_q + 1.
  assign hdr_sel = idx_q + 4'd1;

  always_comb begin
    hdr_word = 9'd0;
    case (hdr_sel)
      4'd0:    hdr_word = mk_word(1'b0, CMD_CASET);
      4'd1:    hdr_word = mk_word(1'b1, x0_w[15:8]);
      4'd2:    hdr_word = mk_word(1'b1, x0_w[7:0]);
      4'd3:    hdr_word = mk_word(1'b1, x1_w[15:8]);
      4'd4:    hdr_word = mk_word(1'b1, x1_w[7:0]);
      4'd5:    hdr_word = mk_word(1'b0, CMD_RASET);
      4'd6:    hdr_word = mk_word(1'b1, y0_w[15:8]);
      4'd7:    hdr_word = mk_word(1'b1, y0_w[7:0]);
      4'd8:    hdr_word = mk_word(1'b1, y1_w[15:8]);
      4'd9:    hdr_word = mk_word(1'b1, y1_w[7:0]);
      4'd10:   hdr_word = mk_word(1'b0, CMD_RAMWR);
      default: hdr_word = 9'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    data_d   = data_q;
    err_d    = err_q;
    latch_en = 1'b0;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          if ((x1 < x0) || (y1 < y0)) begin
            // Invalid window: report immediately, emit nothing
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = HEADER;
            idx_d   = 4'd0;
            valid_d = 1'b1;
            data_d  = mk_word(1'b0, CMD_CASET);
            err_d   = 1'b0;
          end
        end
      end

      HEADER: begin
        if (xfer) begin
          if (idx_q == HDR_LAST_IDX) begin
            state_d  = PIX_HI;
            data_d   = mk_word(1'b1, colour_q[15:8]);
            cnt_load = 1'b1;
          end else begin
            idx_d  = hdr_sel;
            data_d = hdr_word;
          end
        end
      end

      PIX_HI: begin
        if (xfer) begin
          state_d = PIX_LO;
          data_d  = mk_word(1'b1, colour_q[7:0]);
        end
      end

      PIX_LO: begin
        if (xfer) begin
          if (pix_last) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            cnt_adv = 1'b1;
            state_d = PIX_HI;
            data_d  = mk_word(1'b1, colour_q[15:8]);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= 16'd0;
    end else if (latch_en) begin
      x0_q     <= x0;
      x1_q     <= x1;
      y0_q     <= y0;
      y1_q     <= y1;
      colour_q <= colour;
    end
  end

  lcd_win_counter #(
    .W(COORD_WIDTH)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .advance_i (cnt_adv),
    .x_first_i (x0_q),
    .x_last_i  (x1_q),
    .y_first_i (y0_q),
    .y_last_i  (y1_q),
    .last_o    (pix_last)
  );

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign err   = (state_q == DONE) && err_q;
  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: doc/lcd_rect_fill.md
Name: lcd_rect_fill

Overview:
Upstream producer for the LCD word FIFO. On a start strobe it emits a complete ST7789 window-fill transaction as 9-bit FIFO words: CASET, RASET, RAMWR and their parameters, then one RGB565 colour repeated over every pixel of the rectangle. It replaces a fixed RAM-writer pass in the top-level driver's write-memory phase and lets the driver draw arbitrary filled rectangles. Word format: bit 8 is the RS value (0 = command, 1 = data) and bits 7:0 are the payload byte.

Parameters:
COORD_WIDTH, 9, width of the x/y coordinate inputs (legal range 1..16); zero-extended to 16 bits for transmission.
WORD_WIDTH, 9, output word width; fixed at 9, any other value is a configuration error.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  request a fill; sampled only in IDLE
x0  in  COORD_WIDTH  first column (inclusive)
x1  in  COORD_WIDTH  last column (inclusive)
y0  in  COORD_WIDTH  first row (inclusive)
y1  in  COORD_WIDTH  last row (inclusive)
colour  in  16  RGB565 fill colour
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at the end of a transaction
err  out  1  one-cycle pulse, coincident with done, when the rectangle is invalid
valid  out  1  output word valid (FIFO wr_valid)
ready  in  1  FIFO wr_ready
data  out  9  output word (FIFO wr_data)

Behaviour:
- Reset values: valid=0, data=0, busy=0, done=0, err=0, state=IDLE, all counters 0. Reset is honoured at any point; a transaction in flight is abandoned without a partial flush.
- Start handling:
  - When start=1 in IDLE, the block latches x0, x1, y0, y1 and colour in that same cycle.
  - Later changes to these inputs have no effect until the next start.
  - start is ignored outside IDLE.
- Handshake:
  - A word transfers on a cycle where valid and ready are both high.
  - data and valid are registered. Once valid is asserted, neither valid nor data changes until the word transfers.
  - valid may be asserted regardless of ready.
- States: IDLE -> HEADER -> PIX_HI -> PIX_LO -> (PIX_HI | DONE) -> IDLE.
- HEADER emits 11 words, indexed by a 4-bit counter, in this order:
  - 0x02A (CASET), then 0x100|x0[15:8], 0x100|x0[7:0], 0x100|x1[15:8], 0x100|x1[7:0].
  - 0x02B (RASET), then the same four bytes for y0 and y1.
  - 0x02C (RAMWR).
- Pixel phase:
  - PIX_HI emits 0x100|colour[15:8]; PIX_LO emits 0x100|colour[7:0].
  - A column counter runs from x0 to x1; a row counter runs from y0 to y1. No multiplier.
  - When the PIX_LO word for (x1, y1) transfers, the state goes to DONE.
- DONE lasts one cycle: done=1, busy=1, valid=0. The next state is IDLE.
- Latency:
  - start in cycle N gives valid=1 with data=0x02A in cycle N+1.
  - With ready held high, one word transfers per cycle and there are no bubbles between words.
  - The transaction takes 11 + 2*W*H transfer cycles, where W=x1-x0+1 and H=y1-y0+1.
  - done is asserted in the cycle after the final transfer.
- Invalid rectangle (x1<x0 or y1<y0):
  - Goes IDLE -> DONE directly; no word is emitted.
  - done=1 and err=1 in cycle N+1.
- Degenerate rectangle: x0=x1 and y0=y1 is legal and produces exactly one pixel (2 data words).
- Counter width: counters are COORD_WIDTH bits. The x1/y1 comparison is made before incrementing, so there is no wrap for x1=y1=2^COORD_WIDTH-1.
- Backpressure: ready may drop at any cycle, including mid-header and between the hi/lo bytes of a pixel. The word order is unaffected.

Decomposition:
- Shared package lcd_pkg:
  - command opcodes CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C;
  - RS bit index RS_BIT=8;
  - rect_fill_state_t enum {IDLE, HEADER, PIX_HI, PIX_LO, DONE}.
- The header word selection is a combinational mux on the header index inside the module.
- One natural sub-module: lcd_win_counter, a column/row scan counter with load, advance and last outputs. It is reusable by future bitmap and text writers.

Test Plan:
1. Single pixel at (0,0), colour 0xF800, ready=1 -> words 0x02A,0x100,0x100,0x100,0x100,0x02B,0x100,0x100,0x100,0x100,0x02C,0x1F8,0x100 on consecutive cycles; done pulse one cycle later; err=0.
2. Rectangle x 10..12, y 300..301, colour 0x07E0 -> CASET params 0x100,0x10A,0x100,0x10C; RASET params 0x101,0x12C,0x101,0x12D; then 12 words alternating 0x107,0x1E0.
3. Full screen x 0..239, y 0..319 with ready=1 -> 11+153600 transfers, no gaps; done exactly once.
4. Random ready (50% duty) on test 2 -> identical word sequence; data stable while valid&&!ready.
5. x0=5, x1=4 -> no valid assertion; done=err=1 at N+1; busy high for exactly one cycle.
6. start pulses while busy, plus rst asserted after the 7th transfer -> starts ignored; on reset, valid/busy drop immediately; a new start after reset produces a complete, fresh sequence beginning 0x02A.
